dff_stim_checker: RTL and testbench
===================================

# dff_stim_checker

Synthesizable response checker for single-bit D flip-flop lab designs; the observing end of the stimulus/DUT pair. It samples the same d and active-low clear that the stimulus drives into the DUT, keeps a reference flip-flop model, and compares the DUT q on every clock edge. It counts samples and mismatches, records the first failing sample, and reports pass/fail when a run of NUM_SAMPLES comparisons completes. It sits beside the DUT in lab benches and FPGA self-test wrappers.

## Interface
- CNT_W, 8, width of sample/error counters and first-error index
- NUM_SAMPLES, 16, comparisons per run; legal range 1 .. 2^CNT_W-1
- FAIL_FAST, 0, 1 = end the run on the first mismatch
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- abort  in  1  return to IDLE from any state; counters hold
- d_obs  in  1  stimulus d as driven to the DUT
- clrn_obs  in  1  stimulus active-low clear as driven to the DUT
- q_obs  in  1  DUT q output
- busy  out  1  high in PRIME and CHECK
- done  out  1  high in DONE
- pass  out  1  done and err_cnt == 0
- fail  out  1  done and err_cnt != 0
- smp_cnt  out  CNT_W  comparisons performed this run
- err_cnt  out  CNT_W  mismatches this run, saturating at all-ones
- first_err  out  CNT_W  smp_cnt value at first mismatch; all-ones if none

## Operation
- States: IDLE, PRIME, CHECK, DONE.
- IDLE: start=1 at an edge clears smp_cnt and err_cnt, sets first_err to all-ones, and enters PRIME.
- PRIME: one cycle. At its closing edge, captures d_obs into d_m and clrn_obs into c_m, then enters CHECK. No comparison.
- CHECK, each edge:
  - exp = 0 if clrn_obs == 0 at this edge (asynchronous clear dominates); otherwise exp = (c_m ? d_m : 0).
  - Mismatch when q_obs != exp: err_cnt increments, holding at 2^CNT_W-1. If err_cnt was 0, first_err ← current smp_cnt, i.e. the pre-increment value.
  - smp_cnt increments.
  - d_m and c_m recapture.
  - Exit to DONE when the incremented smp_cnt == NUM_SAMPLES, or on a mismatch with FAIL_FAST=1.
- DONE: outputs hold. start=1 begins a new run exactly as from IDLE.
- abort=1 at any edge forces IDLE and overrides start. Counters and first_err keep their values, and done, pass and fail drop.
- start while busy is ignored.
- q_obs, d_obs and clrn_obs are sampled only at rising edges. There is no internal synchronizer; inputs must come from the clk domain.

## Timing
- On clr: state IDLE, busy=0, done=0, pass=0, fail=0, smp_cnt=0, err_cnt=0, first_err=all-ones, d_m=0, c_m=0. Takes effect immediately and asynchronously, including mid-run.
- Counting from the edge that samples start as E0:
  - busy rises after E0.
  - Capture happens at E1.
  - Comparisons happen at E2 .. E(NUM_SAMPLES+1).
  - done, pass and fail are valid after E(NUM_SAMPLES+1), and busy falls at the same edge.
- Outputs are registered with no combinational path from inputs; pass and fail are decoded from state and err_cnt.
- With FAIL_FAST=1 and a mismatch at comparison edge Ek, done is high after Ek, smp_cnt = k-1, and err_cnt = 1.
- start and abort at the same edge: abort wins.

## Test plan
- Correct DFF model, d_obs toggling every cycle, clrn_obs=1, NUM_SAMPLES=8 → done after E9, pass=1, smp_cnt=8, err_cnt=0, first_err=8'hFF.
- q_obs stuck at 0, d_obs alternating starting with 1 at E1, NUM_SAMPLES=8 → err_cnt=4, first_err=0, fail=1.
- clrn_obs low during E4–E5 with the DUT clearing correctly → no mismatches. Holding q_obs=1 instead at E4 → err_cnt=1, first_err=2.
- FAIL_FAST=1, q_obs inverted from E2 → done after E2, smp_cnt=1, err_cnt=1, fail=1.
- CNT_W=3, NUM_SAMPLES=7, q_obs always wrong → err_cnt saturates at 7 and done after E8. start pulsed during CHECK has no effect.
- clr asserted mid-CHECK → all outputs return to reset values without a clock edge. abort mid-run → IDLE with counters holding their values.

Source files
------------

// File: rtl/dff_stim_checker.sv
// Response checker for single-bit D flip-flop lab designs: keeps a reference
// flop model fed from the observed stimulus and scores the DUT q every edge.
//
// state | meaning
// IDLE  | waiting for start; counters hold their last values
// PRIME | one cycle to capture the first d/clear pair into the model
// CHECK | compare q_obs against the model on every edge
// DONE  | run finished; pass/fail valid until start or abort
module dff_stim_checker #(
  parameter int CNT_W       = 8,
  parameter int NUM_SAMPLES = 16,
  parameter bit FAIL_FAST   = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic             d_obs,
  input  logic             clrn_obs,
  input  logic             q_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err
);

  typedef enum logic [1:0] {IDLE, PRIME, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_SAMPLES);

  state_t           state, state_nx;
  logic             d_m, c_m;
  logic             exp_q, mismatch, launch, last;
  logic [CNT_W-1:0] smp_inc;

  // Observed clear at this edge dominates the modelled flop contents.
  assign exp_q    = clrn_obs ? (c_m & d_m) : 1'b0;
  assign mismatch = (state == CHECK) && (q_obs != exp_q);
  assign launch   = start && !abort && ((state == IDLE) || (state == DONE));
  assign smp_inc  = smp_cnt + 1'b1;
  assign last     = (smp_inc == NUM_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_nx = PRIME;
        PRIME:      state_nx = CHECK;
        CHECK:      if (last || (FAIL_FAST && mismatch)) state_nx = DONE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == PRIME) || (state == CHECK);
    done = (state == DONE);
    pass = done && (err_cnt == '0);
    fail = done && (err_cnt != '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      smp_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= ALL_ONES;
      d_m       <= 1'b0;
      c_m       <= 1'b0;
    end else if (launch) begin
      smp_cnt   <= '0;
      err_cnt   <= '0;
      first_err <= ALL_ONES;
    end else if (!abort) begin
      if ((state == PRIME) || (state == CHECK)) begin
        d_m <= d_obs;
        c_m <= clrn_obs;
      end
      if (state == CHECK) begin
        smp_cnt <= smp_inc;
        if (mismatch) begin
          if (err_cnt != ALL_ONES) err_cnt <= err_cnt + 1'b1;
          if (err_cnt == '0)       first_err <= smp_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_stim_checker.sv
// Directed bench for dff_stim_checker: a behavioural DFF produces q, which is
// passed through, stuck, inverted or forced high before reaching the checkers.
module tb_dff_stim_checker;

  logic clk, clr, start, abort, d_obs, clrn_obs, q_obs;
  logic q_dut;
  logic [1:0] q_mode;

  logic busy_a, done_a, pass_a, fail_a;
  logic [7:0] smp_a, err_a, first_a;
  logic busy_f, done_f, pass_f, fail_f;
  logic [7:0] smp_f, err_f, first_f;
  logic busy_s, done_s, pass_s, fail_s;
  logic [2:0] smp_s, err_s, first_s;

  int n_checks = 0;
  int n_fail   = 0;

  dff_stim_checker #(.CNT_W(8), .NUM_SAMPLES(8), .FAIL_FAST(1'b0)) u_a (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .d_obs(d_obs),
    .clrn_obs(clrn_obs), .q_obs(q_obs), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail(fail_a), .smp_cnt(smp_a), .err_cnt(err_a),
    .first_err(first_a));

  dff_stim_checker #(.CNT_W(8), .NUM_SAMPLES(8), .FAIL_FAST(1'b1)) u_f (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .d_obs(d_obs),
    .clrn_obs(clrn_obs), .q_obs(q_obs), .busy(busy_f), .done(done_f),
    .pass(pass_f), .fail(fail_f), .smp_cnt(smp_f), .err_cnt(err_f),
    .first_err(first_f));

  dff_stim_checker #(.CNT_W(3), .NUM_SAMPLES(7), .FAIL_FAST(1'b0)) u_s (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .d_obs(d_obs),
    .clrn_obs(clrn_obs), .q_obs(q_obs), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail(fail_s), .smp_cnt(smp_s), .err_cnt(err_s),
    .first_err(first_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lab DUT stand-in: flop with asynchronous active-low clear.
  always @(posedge clk or negedge clrn_obs) begin
    if (!clrn_obs) q_dut <= 1'b0;
    else           q_dut <= d_obs;
  end

  always_comb begin
    case (q_mode)
      2'd0:    q_obs = q_dut;
      2'd1:    q_obs = 1'b0;
      2'd2:    q_obs = ~q_dut;
      default: q_obs = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Abort syncs all checkers to IDLE, then the start edge is E0.
  task automatic begin_run();
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0;
    d_obs = 1'b0; clrn_obs = 1'b1; q_mode = 2'd0;
    step(); step(); step();
    check("rst_busy",  {7'd0, busy_a}, 8'd0);
    check("rst_done",  {7'd0, done_a}, 8'd0);
    check("rst_pass",  {7'd0, pass_a}, 8'd0);
    check("rst_fail",  {7'd0, fail_a}, 8'd0);
    check("rst_smp",   smp_a,   8'd0);
    check("rst_err",   err_a,   8'd0);
    check("rst_first", first_a, 8'hFF);
    clr = 1'b0;
    step();

    // Correct DUT, toggling d
    q_mode = 2'd0;
    begin_run();
    check("t1_busy_e0", {7'd0, busy_a}, 8'd1);
    for (int k = 1; k <= 9; k++) begin
      d_obs = k[0];
      step();
      if (k == 8) begin
        check("t1_busy_e8", {7'd0, busy_a}, 8'd1);
        check("t1_done_e8", {7'd0, done_a}, 8'd0);
      end
    end
    check("t1_done",  {7'd0, done_a}, 8'd1);
    check("t1_busy",  {7'd0, busy_a}, 8'd0);
    check("t1_pass",  {7'd0, pass_a}, 8'd1);
    check("t1_fail",  {7'd0, fail_a}, 8'd0);
    check("t1_smp",   smp_a,   8'd8);
    check("t1_err",   err_a,   8'd0);
    check("t1_first", first_a, 8'hFF);
    check("t1_ff_pass", {7'd0, pass_f}, 8'd1);

    // q stuck at 0, d alternating from 1 at E1
    q_mode = 2'd1;
    begin_run();
    for (int k = 1; k <= 9; k++) begin
      d_obs = k[0];
      step();
    end
    check("t2_err",   err_a,   8'd4);
    check("t2_first", first_a, 8'd0);
    check("t2_fail",  {7'd0, fail_a}, 8'd1);
    check("t2_pass",  {7'd0, pass_a}, 8'd0);
    check("t2_smp",   smp_a,   8'd8);

    // Clear low at E4-E5, DUT clears correctly
    q_mode = 2'd0;
    begin_run();
    for (int k = 1; k <= 9; k++) begin
      d_obs = k[0];
      clrn_obs = !((k == 4) || (k == 5));
      step();
    end
    check("t3_err",  err_a, 8'd0);
    check("t3_pass", {7'd0, pass_a}, 8'd1);

    // Same, but q held at 1 at E4
    begin_run();
    for (int k = 1; k <= 9; k++) begin
      d_obs = k[0];
      clrn_obs = !((k == 4) || (k == 5));
      q_mode = (k == 4) ? 2'd3 : 2'd0;
      step();
    end
    q_mode = 2'd0;
    check("t3b_err",   err_a,   8'd1);
    check("t3b_first", first_a, 8'd2);
    check("t3b_fail",  {7'd0, fail_a}, 8'd1);

    // Fail-fast with q inverted from E2
    q_mode = 2'd2;
    begin_run();
    d_obs = 1'b1;
    step();
    check("t4_done_e1", {7'd0, done_f}, 8'd0);
    d_obs = 1'b0;
    step();
    check("t4_done", {7'd0, done_f}, 8'd1);
    check("t4_busy", {7'd0, busy_f}, 8'd0);
    check("t4_smp",  smp_f, 8'd1);
    check("t4_err",  err_f, 8'd1);
    check("t4_fail", {7'd0, fail_f}, 8'd1);

    // CNT_W=3 saturation, start pulsed mid-CHECK
    q_mode = 2'd2;
    begin_run();
    for (int k = 1; k <= 8; k++) begin
      d_obs = k[0];
      start = (k == 4);
      step();
      if (k == 7) check("t5_done_e7", {7'd0, done_s}, 8'd0);
    end
    start = 1'b0;
    check("t5_done",  {7'd0, done_s}, 8'd1);
    check("t5_err",   {5'd0, err_s},   8'd7);
    check("t5_smp",   {5'd0, smp_s},   8'd7);
    check("t5_first", {5'd0, first_s}, 8'd0);
    check("t5_fail",  {7'd0, fail_s}, 8'd1);

    // Asynchronous clr mid-CHECK
    q_mode = 2'd1;
    begin_run();
    for (int k = 1; k <= 3; k++) begin
      d_obs = 1'b1;
      step();
    end
    check("t6_pre_smp", smp_a, 8'd2);
    #1 clr = 1'b1;
    #1;
    check("t6_busy",  {7'd0, busy_a}, 8'd0);
    check("t6_done",  {7'd0, done_a}, 8'd0);
    check("t6_smp",   smp_a,   8'd0);
    check("t6_err",   err_a,   8'd0);
    check("t6_first", first_a, 8'hFF);
    #1 clr = 1'b0;
    step();

    // Abort mid-run keeps counters
    q_mode = 2'd1;
    begin_run();
    for (int k = 1; k <= 4; k++) begin
      d_obs = 1'b1;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t7_busy",  {7'd0, busy_a}, 8'd0);
    check("t7_done",  {7'd0, done_a}, 8'd0);
    check("t7_fail",  {7'd0, fail_a}, 8'd0);
    check("t7_smp",   smp_a,   8'd3);
    check("t7_err",   err_a,   8'd3);
    check("t7_first", first_a, 8'd0);

    // Abort wins over start at the same edge
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("t8_busy", {7'd0, busy_a}, 8'd0);
    step();
    check("t8_busy_next", {7'd0, busy_a}, 8'd0);
    check("t8_smp", smp_a, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
